// File: rtl/counter_step_ctrl.sv
// rtl/counter_step_ctrl.sv - button conditioning and step/auto-repeat sequencing for counter_updown
// Optional carry counting on wrap_cnt is built when CTRL_WRAP_CNT_EN is defined.
module counter_step_ctrl #(
  parameter int DEB_CYCLES    = 1000000,
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000,
  parameter int TW            = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_pause,
  input  logic       c_in,
  output logic [1:0] key,
  output logic       pause,
  output logic       rpt_active,
  output logic [7:0] wrap_cnt
);

  localparam logic [TW-1:0] DEB_LAST  = TW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, RPT, WAIT_REL} state_t;

  // Bit order for the conditioned buttons: 0 = up, 1 = down, 2 = pause.
  logic [2:0]    raw;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    deb;
  logic [TW-1:0] deb_cnt [3];

  state_t        state;
  logic          dir;
  logic [TW-1:0] timer;
  logic          pause_deb_q;

  logic          up;
  logic          dn;
  logic          pause_rise;
  logic          held;
  logic          other;
  logic [1:0]    step_key;

  assign raw = {btn_pause, btn_down, btn_up};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign up         = deb[0];
  assign dn         = deb[1];
  assign pause_rise = deb[2] & ~pause_deb_q;
  assign held       = dir ? dn : up;
  assign other      = dir ? up : dn;
  assign step_key   = dir ? 2'b10 : 2'b01;

  // A pause edge or an active pause overrides any step decision in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      dir         <= 1'b0;
      timer       <= '0;
      key         <= 2'b00;
      pause       <= 1'b0;
      rpt_active  <= 1'b0;
      pause_deb_q <= 1'b0;
    end else begin
      key         <= 2'b00;
      pause_deb_q <= deb[2];
      if (pause_rise) pause <= ~pause;
      if (pause || pause_rise) begin
        state      <= WAIT_REL;
        timer      <= '0;
        rpt_active <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (up && dn) begin
              state <= WAIT_REL;
            end else if (up || dn) begin
              key   <= up ? 2'b01 : 2'b10;
              dir   <= dn;
              timer <= '0;
              state <= HOLD;
            end
          end
          HOLD: begin
            if (!held || other) begin
              state <= WAIT_REL;
            end else if (timer == HOLD_LAST) begin
              key        <= step_key;
              timer      <= '0;
              state      <= RPT;
              rpt_active <= 1'b1;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          RPT: begin
            if (!held || other) begin
              state      <= WAIT_REL;
              rpt_active <= 1'b0;
            end else if (timer == REP_LAST) begin
              key   <= step_key;
              timer <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          default: begin
            if (!up && !dn) state <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef CTRL_WRAP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_cnt <= 8'd0;
    end else if (c_in && !pause && (wrap_cnt != 8'hFF)) begin
      wrap_cnt <= wrap_cnt + 8'd1;
    end
  end
`else
  logic unused_c_in;
  assign unused_c_in = c_in;
  assign wrap_cnt    = 8'd0;
`endif

endmodule
